// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard / stall controller.
// Drives the write enables, bubbles and flushes of the four pipeline
// registers from three sources: data-memory wait (highest priority),
// taken-branch flush, and load-use stall (lowest priority).
// Also keeps a sticky memory-timeout flag and a saturating counter of
// cycles in which the PC was held.
//
// Memory handshake: mem_req is held high by the MEM stage for as long as
// it owns a load or store. The access completes in the first cycle where
// mem_req && mem_ready are both high. Any cycle with mem_req && !mem_ready
// freezes the front of the pipeline and pushes a bubble into MEM/WB.
module hazard_stall_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [3:0] LD_INIT = 4'(LOAD_LAT - 1);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic       resume_ld;   // the wait interrupted a load stall
  logic [3:0] ld_cnt;      // remaining load-stall cycles after this one
  logic [7:0] mem_cnt;     // consecutive wait cycles seen so far

  logic hazard_ld;
  logic wait_hold;
  logic do_flush;
  logic do_stall;

  // Hazard detection and per-cycle action selection in priority order.
  always_comb begin
    hazard_ld = ex_memread && (ex_rd != 5'd31) &&
                ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    // In MEMWAIT the freeze lasts until ready; elsewhere it starts on a stalled request.
    wait_hold = (state == MEMWAIT) ? !mem_ready : (mem_req && !mem_ready);
    do_flush  = branch_taken && !wait_hold;
    do_stall  = !wait_hold && !branch_taken &&
                ((state == LDSTALL) || ((state == RUN) && hazard_ld));
  end

  // Pipeline-register control outputs; defaults whenever reset is high.
  always_comb begin
    pc_wren       = 1'b1;
    if_id_wren    = 1'b1;
    id_ex_wren    = 1'b1;
    ex_mem_wren   = 1'b1;
    mem_wb_wren   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset) begin
      if (wait_hold) begin
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        ex_mem_wren   = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (do_flush) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (do_stall) begin
        pc_wren      = 1'b0;
        if_id_wren   = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Control FSM, timeout tracking and stall-cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      resume_ld    <= 1'b0;
      ld_cnt       <= 4'd0;
      mem_cnt      <= 8'd0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!pc_wren && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        RUN, LDSTALL: begin
          if (mem_req && !mem_ready) begin
            // ld_cnt is left untouched so an interrupted load stall resumes.
            state     <= MEMWAIT;
            mem_cnt   <= 8'd1;
            resume_ld <= (state == LDSTALL);
          end else if (branch_taken) begin
            state  <= RUN;
            ld_cnt <= 4'd0;
          end else if (state == LDSTALL) begin
            if (ld_cnt == 4'd1)
              state <= RUN;
            ld_cnt <= ld_cnt - 4'd1;
          end else if (hazard_ld && (LOAD_LAT > 1)) begin
            state  <= LDSTALL;
            ld_cnt <= LD_INIT;
          end
        end
        MEMWAIT: begin
          if (mem_ready) begin
            if (branch_taken) begin
              state  <= RUN;
              ld_cnt <= 4'd0;
            end else begin
              state <= resume_ld ? LDSTALL : RUN;
            end
          end else if (mem_cnt == TIMEOUT) begin
            // Abort the stuck access; the bubble issued this cycle drops it.
            mem_error <= 1'b1;
            state     <= RUN;
            ld_cnt    <= 4'd0;
          end else begin
            mem_cnt <= mem_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. Two instances share the stimulus:
//   dut_a: LOAD_LAT=3, MEM_TIMEOUT=8, CNT_W=4
//   dut_b: LOAD_LAT=1, MEM_TIMEOUT=3, CNT_W=8
// A behavioural model predicts every output on every cycle; directed
// phases add literal expectations, then a long randomized run follows.
module tb_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rm, ex_memread, branch_taken, mem_req, mem_ready;

  logic       pc_wren_a, if_id_wren_a, id_ex_wren_a, ex_mem_wren_a, mem_wb_wren_a;
  logic       if_id_flush_a, id_ex_bubble_a, ex_mem_flush_a, mem_wb_bubble_a, mem_error_a;
  logic [3:0] stall_cycles_a;
  logic       pc_wren_b, if_id_wren_b, id_ex_wren_b, ex_mem_wren_b, mem_wb_wren_b;
  logic       if_id_flush_b, id_ex_bubble_b, ex_mem_flush_b, mem_wb_bubble_b, mem_error_b;
  logic [7:0] stall_cycles_b;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  cmp_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  hazard_stall_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rm(id_uses_rm), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wren(pc_wren_a), .if_id_wren(if_id_wren_a), .id_ex_wren(id_ex_wren_a),
    .ex_mem_wren(ex_mem_wren_a), .mem_wb_wren(mem_wb_wren_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a),
    .ex_mem_flush(ex_mem_flush_a), .mem_wb_bubble(mem_wb_bubble_a),
    .mem_error(mem_error_a), .stall_cycles(stall_cycles_a)
  );

  hazard_stall_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(3), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rm(id_uses_rm), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wren(pc_wren_b), .if_id_wren(if_id_wren_b), .id_ex_wren(id_ex_wren_b),
    .ex_mem_wren(ex_mem_wren_b), .mem_wb_wren(mem_wb_wren_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b),
    .ex_mem_flush(ex_mem_flush_b), .mem_wb_bubble(mem_wb_bubble_b),
    .mem_error(mem_error_b), .stall_cycles(stall_cycles_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit waiting;   // memory access outstanding and pipeline frozen
    int waited;    // wait cycles already spent on this access
    int ld_left;   // load-stall cycles still owed
    bit err;
    int cnt;
  } mdl_t;

  mdl_t ma, mb, na, nb;

  // Output order: pc, if_id, id_ex, ex_mem, mem_wb wren,
  // if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble, mem_error.
  function automatic void mdl_eval(input mdl_t cur, input int lat, input int tmo,
                                   input int cmax, output logic [9:0] o,
                                   output mdl_t nxt);
    logic [3:0] wren5_lo;
    bit freeze = 0, flush = 0, stall = 0, hz;
    nxt = cur;
    hz = ex_memread && (ex_rd != 5'd31) &&
         ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    if (reset) begin
      nxt = '{default:0};
    end else begin
      if (cur.waiting) begin
        if (mem_ready) begin
          nxt.waiting = 0;
          if (branch_taken) begin flush = 1; nxt.ld_left = 0; end
        end else begin
          freeze = 1;
          if (cur.waited == tmo) begin
            nxt.err = 1; nxt.waiting = 0; nxt.ld_left = 0;
          end else begin
            nxt.waited = cur.waited + 1;
          end
        end
      end else if (mem_req && !mem_ready) begin
        freeze = 1; nxt.waiting = 1; nxt.waited = 1;
      end else if (branch_taken) begin
        flush = 1; nxt.ld_left = 0;
      end else if (cur.ld_left > 0) begin
        stall = 1; nxt.ld_left = cur.ld_left - 1;
      end else if (hz) begin
        stall = 1; nxt.ld_left = lat - 1;
      end
      if ((freeze || stall) && cur.cnt < cmax) nxt.cnt = cur.cnt + 1;
    end
    wren5_lo = {!(freeze || stall), !freeze, !freeze, 1'b1};
    o = {!(freeze || stall), wren5_lo, flush, flush || stall, flush, freeze, cur.err};
  endfunction

  wire [9:0] got_a = {pc_wren_a, if_id_wren_a, id_ex_wren_a, ex_mem_wren_a, mem_wb_wren_a,
                      if_id_flush_a, id_ex_bubble_a, ex_mem_flush_a, mem_wb_bubble_a, mem_error_a};
  wire [9:0] got_b = {pc_wren_b, if_id_wren_b, id_ex_wren_b, ex_mem_wren_b, mem_wb_wren_b,
                      if_id_flush_b, id_ex_bubble_b, ex_mem_flush_b, mem_wb_bubble_b, mem_error_b};

  // ---------------- scoreboard: every cycle, mid-period ----------------
  always @(negedge clock) begin
    logic [9:0] exp_a, exp_b;
    mdl_eval(ma, 3, 8, 15, exp_a, na);
    mdl_eval(mb, 1, 3, 255, exp_b, nb);
    if (cmp_en) begin
      n_cmp++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL ctrl_a t=%0t: got %b want %b", $time, got_a, exp_a);
      end
      n_cmp++;
      if (stall_cycles_a !== 4'(ma.cnt)) begin
        n_fail++;
        $display("FAIL stall_cycles_a t=%0t: got %0d want %0d", $time, stall_cycles_a, ma.cnt);
      end
      n_cmp++;
      if (got_b !== exp_b) begin
        n_fail++;
        $display("FAIL ctrl_b t=%0t: got %b want %b", $time, got_b, exp_b);
      end
      n_cmp++;
      if (stall_cycles_b !== 8'(mb.cnt)) begin
        n_fail++;
        $display("FAIL stall_cycles_b t=%0t: got %0d want %0d", $time, stall_cycles_b, mb.cnt);
      end
    end
  end

  always @(posedge clock) begin
    ma = na;
    mb = nb;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0; id_uses_rm = 1'b0;
    ex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic check_lit(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] rand_reg();
    int r = $urandom_range(0, 9);
    return (r < 8) ? 5'(r) : 5'd31;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int rdy_bias;
    ma = '{default:0}; mb = '{default:0}; na = ma; nb = mb;
    idle_inputs();
    reset = 1'b1;
    step(1);
    cmp_en = 1'b1;
    step(1);
    reset = 1'b0;
    check_lit("reset_stall_a", stall_cycles_a, 0);
    check_lit("reset_err_a", mem_error_a, 0);

    // Load-use on id_rn for one cycle.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    #1;
    check_lit("lu_pc_a", pc_wren_a, 0);
    check_lit("lu_bubble_b", id_ex_bubble_b, 1);
    step(1);
    ex_memread = 1'b0;
    #1;
    check_lit("lu_after_pc_b", pc_wren_b, 1);
    check_lit("lu_ldstall_pc_a", pc_wren_a, 0);
    step(4);
    check_lit("lu_cnt_a", stall_cycles_a, 3);
    check_lit("lu_cnt_b", stall_cycles_b, 1);

    // XZR never matches; rm only when used.
    ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
    #1;
    check_lit("xzr_pc_b", pc_wren_b, 1);
    step(1);
    ex_rd = 5'd7; id_rm = 5'd7; id_rn = 5'd0; id_uses_rm = 1'b0;
    #1;
    check_lit("rm_unused_pc_b", pc_wren_b, 1);
    step(1);
    id_uses_rm = 1'b1;
    #1;
    check_lit("rm_used_pc_b", pc_wren_b, 0);
    step(1);
    idle_inputs();
    step(3);
    check_lit("rm_cnt_a", stall_cycles_a, 6);
    check_lit("rm_cnt_b", stall_cycles_b, 2);

    // Branch in the second load-stall cycle cancels the stall.
    do_reset();
    check_lit("rst2_cnt_a", stall_cycles_a, 0);
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    step(1);
    ex_memread = 1'b0; branch_taken = 1'b1;
    #1;
    check_lit("br_flush_a", if_id_flush_a, 1);
    check_lit("br_pc_a", pc_wren_a, 1);
    step(1);
    branch_taken = 1'b0;
    step(3);
    check_lit("br_cnt_a", stall_cycles_a, 1);

    // Memory wait of 4 cycles with a branch held pending.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    #1;
    check_lit("mw_bub_a", mem_wb_bubble_a, 1);
    check_lit("mw_flush_sup_a", if_id_flush_a, 0);
    step(4);
    mem_ready = 1'b1;
    #1;
    check_lit("mw_ready_flush_a", if_id_flush_a, 1);
    check_lit("mw_ready_bub_a", mem_wb_bubble_a, 0);
    step(1);
    idle_inputs();
    step(1);
    check_lit("mw_cnt_a", stall_cycles_a, 4);
    check_lit("mw_err_a", mem_error_a, 0);
    check_lit("mw_err_b", mem_error_b, 1);

    // Timeout: dut_a aborts on the wait cycle that sees MEM_TIMEOUT.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    step(8);
    check_lit("to_err_early_a", mem_error_a, 0);
    step(1);
    check_lit("to_err_a", mem_error_a, 1);
    mem_req = 1'b0;
    step(3);
    check_lit("to_err_sticky_a", mem_error_a, 1);
    check_lit("to_pc_a", pc_wren_a, 1);

    // Counter saturation.
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    step(20);
    ex_memread = 1'b0;
    step(1);
    check_lit("sat_cnt_a", stall_cycles_a, 15);
    check_lit("sat_cnt_b", stall_cycles_b, 20);

    // Reset in the middle of a memory wait.
    mem_req = 1'b1; mem_ready = 1'b0;
    step(3);
    reset = 1'b1;
    #1;
    check_lit("rst_mw_pc_a", pc_wren_a, 1);
    step(1);
    reset = 1'b0; mem_req = 1'b0;
    #1;
    check_lit("rst_mw_cnt_a", stall_cycles_a, 0);
    check_lit("rst_mw_bub_a", mem_wb_bubble_a, 0);
    step(2);

    // Randomized traffic.
    rdy_bias = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) rdy_bias = $urandom_range(1, 9);
      reset        = ($urandom_range(0, 299) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_rd        = rand_reg();
      id_rn        = rand_reg();
      id_rm        = rand_reg();
      id_uses_rm   = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 9) < rdy_bias);
      step(1);
    end
    reset = 1'b0;
    idle_inputs();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
